x_counter_32_bit_checker: RTL and testbench



---
 rtl/x_counter_32_bit_checker.sv | 263 ++++++++++++++++++++++++++
 tb/tb_x_counter_32_bit_checker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/x_counter_32_bit_checker.sv
// ---------------------------------------------------------------------------
// x_counter_32_bit_checker
//
// Receiver-side monitor for a free-running 32-bit up-counter that arrives on
// 32 separate pins. Every cycle the pins are sampled and the new sample is
// compared against the previous one plus one (modulo 2^32). After LOCK_CNT
// consecutive good increments the checker locks. While locked, every bad
// increment pulses o_err, sets the sticky flag and bumps a saturating 8-bit
// error counter. UNLOCK_CNT consecutive bad increments drop lock again.
//
// Optional build macro: X_COUNTER_32_BIT_CHECKER_CLR_EN
//   Adds a synchronous active-high i_clr input that clears the error counter
//   and the sticky flag without disturbing lock state or the sample pipeline.
// ---------------------------------------------------------------------------
module x_counter_32_bit_checker #(
    parameter int LOCK_CNT   = 4,   // good compares in SEARCH to lock (1..15)
    parameter int UNLOCK_CNT = 3    // bad compares in LOCKED to unlock (1..15)
) (
    input  logic i_clk,
    input  logic i_rst_n,
`ifdef X_COUNTER_32_BIT_CHECKER_CLR_EN
    input  logic i_clr,
`endif
    input  logic i_count_31,
    input  logic i_count_30,
    input  logic i_count_29,
    input  logic i_count_28,
    input  logic i_count_27,
    input  logic i_count_26,
    input  logic i_count_25,
    input  logic i_count_24,
    input  logic i_count_23,
    input  logic i_count_22,
    input  logic i_count_21,
    input  logic i_count_20,
    input  logic i_count_19,
    input  logic i_count_18,
    input  logic i_count_17,
    input  logic i_count_16,
    input  logic i_count_15,
    input  logic i_count_14,
    input  logic i_count_13,
    input  logic i_count_12,
    input  logic i_count_11,
    input  logic i_count_10,
    input  logic i_count_9,
    input  logic i_count_8,
    input  logic i_count_7,
    input  logic i_count_6,
    input  logic i_count_5,
    input  logic i_count_4,
    input  logic i_count_3,
    input  logic i_count_2,
    input  logic i_count_1,
    input  logic i_count_0,
    output logic o_locked,
    output logic o_err,
    output logic o_err_sticky,
    output logic o_err_cnt_7,
    output logic o_err_cnt_6,
    output logic o_err_cnt_5,
    output logic o_err_cnt_4,
    output logic o_err_cnt_3,
    output logic o_err_cnt_2,
    output logic o_err_cnt_1,
    output logic o_err_cnt_0
);

    // FSM encoding
    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Run-counter thresholds narrowed to the 4-bit run counter width
    localparam logic [3:0] LOCK_TH   = LOCK_CNT[3:0];
    localparam logic [3:0] UNLOCK_TH = UNLOCK_CNT[3:0];
    localparam logic [3:0] RUN_MAX   = 4'hF;
    localparam logic [7:0] ERR_MAX   = 8'hFF;

    // -----------------------------------------------------------------------
    // Pin gathering
    // -----------------------------------------------------------------------
    logic [31:0] w_count;

    assign w_count = {
        i_count_31, i_count_30, i_count_29, i_count_28,
        i_count_27, i_count_26, i_count_25, i_count_24,
        i_count_23, i_count_22, i_count_21, i_count_20,
        i_count_19, i_count_18, i_count_17, i_count_16,
        i_count_15, i_count_14, i_count_13, i_count_12,
        i_count_11, i_count_10, i_count_9,  i_count_8,
        i_count_7,  i_count_6,  i_count_5,  i_count_4,
        i_count_3,  i_count_2,  i_count_1,  i_count_0
    };

    // Clear request; tied off when the clear feature is not built in
    logic w_clr;

`ifdef X_COUNTER_32_BIT_CHECKER_CLR_EN
    assign w_clr = i_clr;
`else
    assign w_clr = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Stage 1: sample pipeline
    // -----------------------------------------------------------------------
    logic [31:0] r_in_q;
    logic [31:0] r_prev_q;
    logic        r_in_vld;
    logic        r_prev_vld;

    // Shift the pins into in_q and the old in_q into prev_q; valid flags
    // follow the same two-deep shift so a compare is only trusted once both
    // registers hold real samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_in_q     <= 32'h0000_0000;
            r_prev_q   <= 32'h0000_0000;
            r_in_vld   <= 1'b0;
            r_prev_vld <= 1'b0;
        end else begin
            r_in_q     <= w_count;
            r_prev_q   <= r_in_q;
            r_in_vld   <= 1'b1;
            r_prev_vld <= r_in_vld;
        end
    end

    // -----------------------------------------------------------------------
    // Increment comparator
    // -----------------------------------------------------------------------
    logic [31:0] w_prev_inc;
    logic [31:0] w_bit_eq;
    logic        w_good;

    // 32-bit wrap is natural: 0xFFFFFFFF + 1 truncates to 0x00000000
    assign w_prev_inc = r_prev_q + 32'd1;

    // Per-bit equality so a miscompare can be traced to a single pin
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_bit_eq
            assign w_bit_eq[gi] = ~(r_in_q[gi] ^ w_prev_inc[gi]);
        end
    endgenerate

    assign w_good = &w_bit_eq;

    // -----------------------------------------------------------------------
    // Stage 2: lock FSM and run counters
    // -----------------------------------------------------------------------
    logic [0:0] r_state;
    logic [3:0] r_good_run;
    logic [3:0] r_bad_run;
    logic       r_err;

    logic [0:0] w_state_next;
    logic [3:0] w_good_run_next;
    logic [3:0] w_bad_run_next;
    logic [3:0] w_good_run_inc;
    logic [3:0] w_bad_run_inc;
    logic       w_err_next;

    // Saturating increments of the run counters
    assign w_good_run_inc = (r_good_run == RUN_MAX) ? RUN_MAX : (r_good_run + 4'd1);
    assign w_bad_run_inc  = (r_bad_run  == RUN_MAX) ? RUN_MAX : (r_bad_run  + 4'd1);

    // Next-state decode; nothing moves until a trustworthy compare exists
    always_comb begin
        w_state_next    = r_state;
        w_good_run_next = r_good_run;
        w_bad_run_next  = r_bad_run;
        w_err_next      = 1'b0;

        if (r_prev_vld) begin
            case (r_state)
                ST_SEARCH: begin
                    // Errors here are expected while hunting for the count
                    if (w_good) begin
                        w_good_run_next = w_good_run_inc;
                        if (w_good_run_inc >= LOCK_TH) begin
                            w_state_next   = ST_LOCKED;
                            w_bad_run_next = 4'd0;
                        end
                    end else begin
                        w_good_run_next = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (w_good) begin
                        w_bad_run_next = 4'd0;
                    end else begin
                        // The compare that causes the unlock is still an error
                        w_err_next     = 1'b1;
                        w_bad_run_next = w_bad_run_inc;
                        if (w_bad_run_inc >= UNLOCK_TH) begin
                            w_state_next    = ST_SEARCH;
                            w_good_run_next = 4'd0;
                        end
                    end
                end
                default: begin
                    w_state_next    = ST_SEARCH;
                    w_good_run_next = 4'd0;
                    w_bad_run_next  = 4'd0;
                end
            endcase
        end
    end

    // Register FSM state, run counters and the one-cycle error pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_SEARCH;
            r_good_run <= 4'd0;
            r_bad_run  <= 4'd0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_good_run <= w_good_run_next;
            r_bad_run  <= w_bad_run_next;
            r_err      <= w_err_next;
        end
    end

    // -----------------------------------------------------------------------
    // Error accounting
    // -----------------------------------------------------------------------
    logic [7:0] r_err_cnt;
    logic       r_err_sticky;

    // Count and latch errors; a clear at the same edge beats a new error so
    // software sees a clean slate right after it asks for one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_cnt    <= 8'h00;
            r_err_sticky <= 1'b0;
        end else if (w_clr) begin
            r_err_cnt    <= 8'h00;
            r_err_sticky <= 1'b0;
        end else if (w_err_next) begin
            r_err_sticky <= 1'b1;
            if (r_err_cnt != ERR_MAX) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all straight from registers, so reset forces them low at once)
    // -----------------------------------------------------------------------
    assign o_locked     = (r_state == ST_LOCKED);
    assign o_err        = r_err;
    assign o_err_sticky = r_err_sticky;
    assign o_err_cnt_7  = r_err_cnt[7];
    assign o_err_cnt_6  = r_err_cnt[6];
    assign o_err_cnt_5  = r_err_cnt[5];
    assign o_err_cnt_4  = r_err_cnt[4];
    assign o_err_cnt_3  = r_err_cnt[3];
    assign o_err_cnt_2  = r_err_cnt[2];
    assign o_err_cnt_1  = r_err_cnt[1];
    assign o_err_cnt_0  = r_err_cnt[0];

endmodule

// File: tb/tb_x_counter_32_bit_checker.sv
// ---------------------------------------------------------------------------
// Directed testbench for x_counter_32_bit_checker. Pins are driven #1 after
// each rising edge and outputs are sampled at the same point, so each step()
// observes the result of exactly one edge.
// ---------------------------------------------------------------------------
module tb_x_counter_32_bit_checker;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr   = 1'b0;
    logic [31:0] cnt   = 32'h0;
    logic [31:0] nxt;

    wire         locked;
    wire         err;
    wire         sticky;
    wire  [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    x_counter_32_bit_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
`ifdef X_COUNTER_32_BIT_CHECKER_CLR_EN
        .i_clr(clr),
`endif
        .i_count_31(cnt[31]), .i_count_30(cnt[30]), .i_count_29(cnt[29]), .i_count_28(cnt[28]),
        .i_count_27(cnt[27]), .i_count_26(cnt[26]), .i_count_25(cnt[25]), .i_count_24(cnt[24]),
        .i_count_23(cnt[23]), .i_count_22(cnt[22]), .i_count_21(cnt[21]), .i_count_20(cnt[20]),
        .i_count_19(cnt[19]), .i_count_18(cnt[18]), .i_count_17(cnt[17]), .i_count_16(cnt[16]),
        .i_count_15(cnt[15]), .i_count_14(cnt[14]), .i_count_13(cnt[13]), .i_count_12(cnt[12]),
        .i_count_11(cnt[11]), .i_count_10(cnt[10]), .i_count_9(cnt[9]),   .i_count_8(cnt[8]),
        .i_count_7(cnt[7]),   .i_count_6(cnt[6]),   .i_count_5(cnt[5]),   .i_count_4(cnt[4]),
        .i_count_3(cnt[3]),   .i_count_2(cnt[2]),   .i_count_1(cnt[1]),   .i_count_0(cnt[0]),
        .o_locked(locked),
        .o_err(err),
        .o_err_sticky(sticky),
        .o_err_cnt_7(err_cnt[7]), .o_err_cnt_6(err_cnt[6]), .o_err_cnt_5(err_cnt[5]), .o_err_cnt_4(err_cnt[4]),
        .o_err_cnt_3(err_cnt[3]), .o_err_cnt_2(err_cnt[2]), .o_err_cnt_1(err_cnt[1]), .o_err_cnt_0(err_cnt[0])
    );

    // Drive one value, let one edge pass, report the result
    task automatic step(input logic [31:0] v);
        cnt = v;
        @(posedge clk);
        #1;
        $display("step pins=%h locked=%b err=%b sticky=%b cnt=%h", v, locked, err, sticky, err_cnt);
    endtask

    // Hold reset across two edges, release #1 after an edge
    task automatic do_reset();
        rst_n = 1'b0;
        clr   = 1'b0;
        cnt   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reset, then six clean edges starting at 'start' to reach lock
    task automatic reset_and_lock(input logic [31:0] start);
        do_reset();
        for (int i = 0; i < 6; i++) step(start + i);
        nxt = start + 32'd6;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (locked !== 1'b0)   begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (sticky !== 1'b0)   begin errors++; $display("FAIL reset_sticky: got %b want 0", sticky); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL reset_cnt: got %h want 00", err_cnt); end
        for (int k = 1; k <= 6; k++) begin
            step(32'(k - 1));
            if (k == 5) begin
                checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b want 0 after edge 5", locked); end
            end
        end
        checks++; if (locked !== 1'b1)   begin errors++; $display("FAIL lock_edge6: got %b want 1", locked); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL lock_cnt: got %h want 00", err_cnt); end
        checks++; if (sticky !== 1'b0)   begin errors++; $display("FAIL lock_sticky: got %b want 0", sticky); end
    endtask

    task automatic test_wrap();
        reset_and_lock(32'hFFFF_FFF8);
        for (int i = 0; i < 6; i++) begin
            step(32'hFFFF_FFFE + 32'(i));
            checks++; if (err !== 1'b0)    begin errors++; $display("FAIL wrap_err[%0d]: got %b want 0", i, err); end
            checks++; if (locked !== 1'b1) begin errors++; $display("FAIL wrap_locked[%0d]: got %b want 1", i, locked); end
        end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL wrap_cnt: got %h want 00", err_cnt); end
        checks++; if (sticky !== 1'b0)   begin errors++; $display("FAIL wrap_sticky: got %b want 0", sticky); end
    endtask

    task automatic test_glitch();
        reset_and_lock(32'h40);
        for (int v = 'h46; v <= 'h4F; v++) step(32'(v));
        step(32'h100);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL glitch_lat1: got %b want 0", err); end
        step(32'h51);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL glitch_in: got %b want 1", err); end
        step(32'h52);
        checks++; if (err !== 1'b1)      begin errors++; $display("FAIL glitch_out: got %b want 1", err); end
        checks++; if (err_cnt !== 8'h02) begin errors++; $display("FAIL glitch_cnt2: got %h want 02", err_cnt); end
        step(32'h53);
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL glitch_clean: got %b want 0", err); end
        checks++; if (err_cnt !== 8'h02) begin errors++; $display("FAIL glitch_cnt: got %h want 02", err_cnt); end
        checks++; if (sticky !== 1'b1)   begin errors++; $display("FAIL glitch_sticky: got %b want 1", sticky); end
        checks++; if (locked !== 1'b1)   begin errors++; $display("FAIL glitch_locked: got %b want 1", locked); end
    endtask

    task automatic test_freeze();
        logic exp_err;
        logic exp_lock;
        reset_and_lock(32'h1000);
        for (int v = 'h1006; v <= 'h100F; v++) step(32'(v));
        for (int i = 1; i <= 5; i++) begin
            step(32'h1234);
            exp_err  = (i >= 2 && i <= 4);
            exp_lock = (i <= 3);
            checks++; if (err !== exp_err)    begin errors++; $display("FAIL freeze_err[%0d]: got %b want %b", i, err, exp_err); end
            checks++; if (locked !== exp_lock) begin errors++; $display("FAIL freeze_locked[%0d]: got %b want %b", i, locked, exp_lock); end
        end
        checks++; if (err_cnt !== 8'h03) begin errors++; $display("FAIL freeze_cnt: got %h want 03", err_cnt); end
        for (int j = 0; j <= 4; j++) begin
            step(32'h1235 + 32'(j));
            exp_lock = (j == 4);
            checks++; if (locked !== exp_lock) begin errors++; $display("FAIL relock[%0d]: got %b want %b", j, locked, exp_lock); end
            checks++; if (err !== 1'b0)        begin errors++; $display("FAIL relock_err[%0d]: got %b want 0", j, err); end
        end
        checks++; if (err_cnt !== 8'h03) begin errors++; $display("FAIL relock_cnt: got %h want 03", err_cnt); end
    endtask

    task automatic test_saturate();
        reset_and_lock(32'h0);
        for (int g = 0; g < 130; g++) begin
            for (int s = 0; s < 10; s++) begin
                step((s == 0) ? (nxt ^ 32'h8000_0000) : nxt);
                nxt = nxt + 32'd1;
            end
            if (g == 0) begin
                checks++; if (err_cnt !== 8'h02) begin errors++; $display("FAIL sat_first: got %h want 02", err_cnt); end
            end
            if (g == 126) begin
                checks++; if (err_cnt !== 8'hFE) begin errors++; $display("FAIL sat_254: got %h want fe", err_cnt); end
            end
            if (g == 127) begin
                checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_255: got %h want ff", err_cnt); end
            end
        end
        checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_final: got %h want ff", err_cnt); end
        checks++; if (locked !== 1'b1)   begin errors++; $display("FAIL sat_locked: got %b want 1", locked); end
    endtask

    task automatic test_async_reset();
        reset_and_lock(32'h500);
        step(32'h506 ^ 32'h0001_0000);
        step(32'h507);
        step(32'h508);
        checks++; if (err_cnt !== 8'h02) begin errors++; $display("FAIL pre_rst_cnt: got %h want 02", err_cnt); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (locked !== 1'b0)   begin errors++; $display("FAIL arst_locked: got %b want 0", locked); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL arst_cnt: got %h want 00", err_cnt); end
        checks++; if (sticky !== 1'b0)   begin errors++; $display("FAIL arst_sticky: got %b want 0", sticky); end
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(32'h777 + 32'(k - 1));
            if (k == 5) begin
                checks++; if (locked !== 1'b0) begin errors++; $display("FAIL arst_relock_early: got %b want 0", locked); end
            end
        end
        checks++; if (locked !== 1'b1)   begin errors++; $display("FAIL arst_relock: got %b want 1", locked); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL arst_relock_cnt: got %h want 00", err_cnt); end
    endtask

`ifdef X_COUNTER_32_BIT_CHECKER_CLR_EN
    task automatic test_clear();
        reset_and_lock(32'h900);
        step(32'h906 ^ 32'h0000_8000);
        step(32'h907);
        step(32'h908);
        checks++; if (err_cnt !== 8'h02) begin errors++; $display("FAIL clr_pre_cnt: got %h want 02", err_cnt); end
        clr = 1'b1;
        step(32'h909);
        clr = 1'b0;
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL clr_cnt: got %h want 00", err_cnt); end
        checks++; if (sticky !== 1'b0)   begin errors++; $display("FAIL clr_sticky: got %b want 0", sticky); end
        checks++; if (locked !== 1'b1)   begin errors++; $display("FAIL clr_locked: got %b want 1", locked); end
        step(32'h90A ^ 32'h0000_8000);
        clr = 1'b1;
        step(32'h90B);
        clr = 1'b0;
        checks++; if (err !== 1'b1)      begin errors++; $display("FAIL clr_wins_err: got %b want 1", err); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL clr_wins_cnt: got %h want 00", err_cnt); end
        step(32'h90C);
        checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL clr_after_cnt: got %h want 01", err_cnt); end
        checks++; if (sticky !== 1'b1)   begin errors++; $display("FAIL clr_after_sticky: got %b want 1", sticky); end
    endtask
`endif

    initial begin
        test_reset();
        test_wrap();
        test_glitch();
        test_freeze();
        test_saturate();
        test_async_reset();
`ifdef X_COUNTER_32_BIT_CHECKER_CLR_EN
        test_clear();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
